// File: rtl/ofdm_symbol_sync_gen.sv
// Symbol-timing detector: short vs long block averages on I and Q arm a
// SYMBOL_LEN-sample Avalon-ST capture, followed by a GUARD_LEN-cycle hold-off.
module ofdm_symbol_sync_gen #(
    parameter int DATA_W     = 16,
    parameter int LONG_LOG2  = 5,
    parameter int SHORT_LOG2 = 1,
    parameter int THRESHOLD  = 100,
    parameter int SYMBOL_LEN = 64,
    parameter int GUARD_LEN  = 512,
    parameter int NEGATE     = 1
) (
    input  logic                  clock_clk,
    input  logic                  reset_reset,
    input  logic                  sync_enable,
    input  logic [2*DATA_W-1:0]   asi_in0_data,
    input  logic                  asi_in0_valid,
    output logic [2*DATA_W-1:0]   aso_out0_data,
    output logic                  aso_out0_valid,
    output logic                  aso_out0_startofpacket,
    output logic                  aso_out0_endofpacket,
    output logic                  pre_sampling,
    output logic [1:0]            sync_state,
    output logic [15:0]           sync_count
);

    localparam int ACC_W   = DATA_W + LONG_LOG2;
    localparam int SHORT_N = 1 << SHORT_LOG2;
    localparam int SIDX_W  = (SHORT_LOG2 > 0) ? SHORT_LOG2 : 1;
    localparam int CNT_W   = $clog2(SYMBOL_LEN + 1);
    localparam int GUARD_W = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;

    localparam logic [LONG_LOG2-1:0] LIDX_MAX = '1;
    localparam logic [DATA_W:0]      THR      = (DATA_W+1)'(THRESHOLD);
    localparam logic [DATA_W-1:0]    MIN_V    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]    MAX_V    = ~MIN_V;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        CAPTURE = 2'd1,
        GUARD   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Index 0 is the I channel, index 1 the Q channel.
    logic signed [DATA_W-1:0] x        [2];
    logic signed [ACC_W-1:0]  lacc     [2];
    logic signed [ACC_W-1:0]  sacc     [2];
    logic signed [ACC_W-1:0]  lsum     [2];
    logic signed [ACC_W-1:0]  ssum     [2];
    logic signed [DATA_W-1:0] long_avg [2];
    logic signed [DATA_W-1:0] lavg_new [2];
    logic signed [DATA_W-1:0] savg_new [2];
    logic signed [DATA_W:0]   diff     [2];
    logic        [DATA_W:0]   mag      [2];
    logic                     exceed   [2];

    logic [LONG_LOG2-1:0] lidx;
    logic [SIDX_W-1:0]    sidx;
    logic                 settled;
    logic [CNT_W-1:0]     out_cnt;
    logic [GUARD_W-1:0]   gcnt;

    logic long_done;
    logic short_done;
    logic trigger;
    logic guard_done;
    logic emit;

    assign x[0] = asi_in0_data[2*DATA_W-1:DATA_W];
    assign x[1] = asi_in0_data[DATA_W-1:0];

    function automatic logic [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (NEGATE == 0) begin
            r = v;
        end else if (v == MIN_V) begin
            r = MAX_V;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    assign long_done  = (lidx == LIDX_MAX);
    assign short_done = (int'(sidx) == SHORT_N - 1);

    // Distance uses the freshly completed short block against the long
    // average still held in the register (pre-update value).
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            lsum[c]     = lacc[c] + ACC_W'(x[c]);
            ssum[c]     = sacc[c] + ACC_W'(x[c]);
            lavg_new[c] = DATA_W'(lsum[c] >>> LONG_LOG2);
            savg_new[c] = DATA_W'(ssum[c] >>> SHORT_LOG2);
            diff[c]     = (DATA_W+1)'(savg_new[c]) - (DATA_W+1)'(long_avg[c]);
            mag[c]      = diff[c][DATA_W] ? $unsigned(-diff[c]) : $unsigned(diff[c]);
            exceed[c]   = (mag[c] > THR);
        end
    end

    assign trigger = (state_q == ARM) && asi_in0_valid && short_done &&
                     sync_enable && settled && (exceed[0] || exceed[1]);

    assign guard_done = (GUARD_LEN == 0) || (int'(gcnt) + 1 >= GUARD_LEN);

    assign emit = (state_q == CAPTURE) && asi_in0_valid && (int'(out_cnt) != SYMBOL_LEN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (trigger) state_d = CAPTURE;
            CAPTURE: if (aso_out0_endofpacket) state_d = GUARD;
            GUARD:   if (guard_done) state_d = ARM;
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int c = 0; c < 2; c++) begin
                lacc[c]     <= '0;
                sacc[c]     <= '0;
                long_avg[c] <= '0;
            end
            lidx                   <= '0;
            sidx                   <= '0;
            settled                <= 1'b0;
            out_cnt                <= '0;
            gcnt                   <= '0;
            sync_count             <= '0;
            aso_out0_data          <= '0;
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
        end else begin
            aso_out0_valid         <= 1'b0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
            case (state_q)
                ARM: begin
                    if (asi_in0_valid) begin
                        for (int c = 0; c < 2; c++) begin
                            if (long_done) begin
                                long_avg[c] <= lavg_new[c];
                                lacc[c]     <= '0;
                            end else begin
                                lacc[c]     <= lsum[c];
                            end
                            sacc[c] <= short_done ? '0 : ssum[c];
                        end
                        lidx <= long_done ? '0 : lidx + 1'b1;
                        sidx <= short_done ? '0 : sidx + 1'b1;
                        if (long_done) settled <= 1'b1;
                    end
                    if (trigger) out_cnt <= '0;
                end
                CAPTURE: begin
                    if (emit) begin
                        aso_out0_valid         <= 1'b1;
                        aso_out0_data          <= {neg_sat(x[0]), neg_sat(x[1])};
                        aso_out0_startofpacket <= (out_cnt == '0);
                        aso_out0_endofpacket   <= (int'(out_cnt) == SYMBOL_LEN - 1);
                        out_cnt                <= out_cnt + 1'b1;
                    end
                    // Leaving for GUARD: detector restarts from scratch on re-arm.
                    if (aso_out0_endofpacket) begin
                        sync_count <= sync_count + 16'd1;
                        for (int c = 0; c < 2; c++) begin
                            lacc[c]     <= '0;
                            sacc[c]     <= '0;
                            long_avg[c] <= '0;
                        end
                        lidx    <= '0;
                        sidx    <= '0;
                        settled <= 1'b0;
                        gcnt    <= '0;
                    end
                end
                GUARD: begin
                    gcnt <= gcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pre_sampling = (state_q != CAPTURE);
    assign sync_state   = state_q;

endmodule

// File: tb/tb_ofdm_symbol_sync_gen.sv
// Randomised bench for ofdm_symbol_sync_gen: a sample-list reference model
// predicts every output each cycle; directed steps cover the trigger edges.
module tb_ofdm_symbol_sync_gen;

    localparam int W    = 16;
    localparam int LL   = 5;
    localparam int SL   = 1;
    localparam int TH   = 100;
    localparam int SYM  = 64;
    localparam int GL   = 512;
    localparam int NEG  = 1;

    logic            clock_clk = 1'b0;
    logic            reset_reset = 1'b0;
    logic            sync_enable = 1'b1;
    logic [2*W-1:0]  asi_in0_data = '0;
    logic            asi_in0_valid = 1'b0;
    logic [2*W-1:0]  aso_out0_data;
    logic            aso_out0_valid;
    logic            aso_out0_startofpacket;
    logic            aso_out0_endofpacket;
    logic            pre_sampling;
    logic [1:0]      sync_state;
    logic [15:0]     sync_count;

    ofdm_symbol_sync_gen #(
        .DATA_W(W), .LONG_LOG2(LL), .SHORT_LOG2(SL), .THRESHOLD(TH),
        .SYMBOL_LEN(SYM), .GUARD_LEN(GL), .NEGATE(NEG)
    ) dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .sync_enable            (sync_enable),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (asi_in0_valid),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket),
        .pre_sampling           (pre_sampling),
        .sync_state             (sync_state),
        .sync_count             (sync_count)
    );

    always #5 clock_clk = ~clock_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out_seen   = 0;
    int n_guard_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: keeps every sample seen since arming and derives block
    // averages as floor(sum / window) over the relevant tail of that list.
    int          si[$];
    int          sq[$];
    int          m_mode;
    int          m_out_n;
    int          m_g;
    int          m_count;
    int          l_avg_i, l_avg_q;
    bit          m_settled;
    logic        m_valid, m_sop, m_eop;
    logic [31:0] m_data;

    function automatic int tail_avg(input bit use_q, input int k);
        int n = si.size();
        int s = 0;
        for (int j = n - (1 << k); j < n; j++) s += use_q ? sq[j] : si[j];
        return s >>> k;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int neg_ref(input int v);
        int r;
        if (NEG == 0) return v;
        r = -v;
        if (r > (1 << (W-1)) - 1) r = (1 << (W-1)) - 1;
        return r;
    endfunction

    task automatic model_clear();
        si.delete();
        sq.delete();
        l_avg_i   = 0;
        l_avg_q   = 0;
        m_settled = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_mode  = 0;
        m_out_n = 0;
        m_g     = 0;
        m_count = 0;
        m_valid = 0;
        m_sop   = 0;
        m_eop   = 0;
        m_data  = '0;
    endtask

    task automatic model_step(input bit v, input int i, input int q, input bit en);
        int n, a_i, a_q, ni, nq;
        bit trig;
        logic [31:0] pi, pq;
        case (m_mode)
            0: begin
                m_valid = 0; m_sop = 0; m_eop = 0;
                if (v) begin
                    si.push_back(i);
                    sq.push_back(q);
                    n = si.size();
                    trig = 0;
                    if (n % (1 << SL) == 0) begin
                        a_i = tail_avg(0, SL);
                        a_q = tail_avg(1, SL);
                        trig = en && m_settled &&
                               (iabs(a_i - l_avg_i) > TH || iabs(a_q - l_avg_q) > TH);
                    end
                    if (n % (1 << LL) == 0) begin
                        l_avg_i   = tail_avg(0, LL);
                        l_avg_q   = tail_avg(1, LL);
                        m_settled = 1;
                    end
                    if (trig) begin
                        m_mode  = 1;
                        m_out_n = 0;
                    end
                end
            end
            1: begin
                if (m_eop) begin
                    m_mode  = 2;
                    m_count = (m_count + 1) % 65536;
                    m_g     = 0;
                    model_clear();
                    m_valid = 0; m_sop = 0; m_eop = 0;
                end else if (v && m_out_n < SYM) begin
                    ni = neg_ref(i);
                    nq = neg_ref(q);
                    pi = ni;
                    pq = nq;
                    m_valid = 1;
                    m_data  = {pi[W-1:0], pq[W-1:0]};
                    m_sop   = (m_out_n == 0);
                    m_eop   = (m_out_n == SYM - 1);
                    m_out_n++;
                end else begin
                    m_valid = 0; m_sop = 0; m_eop = 0;
                end
            end
            default: begin
                m_valid = 0; m_sop = 0; m_eop = 0;
                m_g++;
                if (m_g >= GL) m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_outputs();
        check("valid", 32'(aso_out0_valid), 32'(m_valid));
        check("sop", 32'(aso_out0_startofpacket), 32'(m_sop));
        check("eop", 32'(aso_out0_endofpacket), 32'(m_eop));
        check("data", aso_out0_data, m_data);
        check("pre_sampling", 32'(pre_sampling), 32'(m_mode != 1));
        check("sync_state", 32'(sync_state), 32'(m_mode));
        check("sync_count", 32'(sync_count), 32'(m_count));
        if (aso_out0_valid) n_out_seen++;
        if (sync_state == 2'd2) n_guard_seen++;
    endtask

    // One clock: check what the last edge produced, then present new inputs.
    task automatic step(input bit v, input int i, input int q);
        logic [31:0] pi, pq;
        @(negedge clock_clk);
        compare_outputs();
        pi = i;
        pq = q;
        asi_in0_valid = v;
        asi_in0_data  = {pi[W-1:0], pq[W-1:0]};
        model_step(v, i, q, sync_enable);
    endtask

    task automatic feed(input int n, input int i, input int q, input int noise, input int gap_mode);
        int ni, nq;
        for (int k = 0; k < n; k++) begin
            if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 2) == 0))
                step(0, int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
            ni = i + int'($urandom_range(0, 2*noise)) - noise;
            nq = q + int'($urandom_range(0, 2*noise)) - noise;
            step(1, ni, nq);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock_clk);
        asi_in0_valid = 0;
        reset_reset   = 1;
        #1;
        check("rst_data", aso_out0_data, 32'h0);
        check("rst_valid", 32'(aso_out0_valid), 32'h0);
        check("rst_sop", 32'(aso_out0_startofpacket), 32'h0);
        check("rst_eop", 32'(aso_out0_endofpacket), 32'h0);
        check("rst_pre", 32'(pre_sampling), 32'h1);
        check("rst_state", 32'(sync_state), 32'h0);
        check("rst_count", 32'(sync_count), 32'h0);
        model_reset();
        @(negedge clock_clk);
        reset_reset = 0;
        model_step(0, 0, 0, sync_enable);
    endtask

    int out_base, guard_base;

    initial begin
        model_reset();
        do_reset();

        // Baseline: settle at zero, I steps to 500, packet then guard then re-arm.
        out_base   = n_out_seen;
        guard_base = n_guard_seen;
        feed(32, 0, 0, 0, 0);
        feed(100, 500, 0, 0, 0);
        feed(600, 500, 0, 0, 0);
        check("base_count", 32'(sync_count), 32'd1);
        check("base_outputs", 32'(n_out_seen - out_base), 32'd64);
        check("base_guard_cycles", 32'(n_guard_seen - guard_base), 32'd512);
        check("base_rearmed", 32'(sync_state), 32'd0);

        // Threshold edge: a step of exactly THRESHOLD must not trigger.
        do_reset();
        feed(32, 0, 0, 0, 0);
        feed(40, 100, 0, 0, 0);
        idle(2);
        check("thr_equal_state", 32'(sync_state), 32'd0);
        check("thr_equal_count", 32'(sync_count), 32'd0);

        do_reset();
        feed(32, 0, 0, 0, 0);
        feed(2, 0, 101, 0, 0);
        @(posedge clock_clk); #1;
        check("thr_above_state", 32'(sync_state), 32'd1);
        feed(70, 0, 101, 0, 0);
        idle(2);
        check("thr_above_count", 32'(sync_count), 32'd1);

        // Saturating negation of the most negative value.
        do_reset();
        feed(32, 0, 0, 0, 0);
        feed(2, 500, 0, 0, 0);
        step(1, -32768, 32767);
        @(posedge clock_clk); #1;
        check("sat_data", aso_out0_data, 32'h7fff_8001);
        feed(70, 1234, -4321, 50, 1);

        // Enable low suppresses, then a -400 step with alternating valid.
        do_reset();
        sync_enable = 0;
        feed(32, 0, 0, 0, 0);
        feed(40, 500, 0, 0, 0);
        idle(2);
        check("en_off_state", 32'(sync_state), 32'd0);
        sync_enable = 1;
        out_base = n_out_seen;
        feed(80, 100, 0, 3, 2);
        idle(3);
        check("en_on_count", 32'(sync_count), 32'd1);
        check("en_on_outputs", 32'(n_out_seen - out_base), 32'd64);

        // Reset in the middle of a packet, then a fresh settle is needed.
        do_reset();
        feed(32, 0, 0, 0, 0);
        feed(2, 500, 0, 0, 0);
        for (int k = 0; k < 200 && m_out_n < 30; k++) feed(1, 700, -700, 20, 1);
        @(posedge clock_clk); #1;
        check("mid_out30_valid", 32'(aso_out0_valid), 32'd1);
        do_reset();
        feed(30, 0, 0, 0, 0);
        feed(2, 500, 0, 0, 0);
        @(posedge clock_clk); #1;
        check("resettle_no_trig", 32'(sync_state), 32'd0);
        feed(2, 500, 0, 0, 0);
        @(posedge clock_clk); #1;
        check("resettle_trig", 32'(sync_state), 32'd1);
        feed(70, -300, 300, 10, 1);

        // Random levels, gaps and enable toggling against the model.
        for (int b = 0; b < 40; b++) begin
            sync_enable = ($urandom_range(0, 3) != 0);
            feed(int'($urandom_range(4, 40)),
                 int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 60)), 1);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
